// File: rtl/cavlc_coeff_scan_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cavlc_pkg                                                            |
// | Shared constants and FSM encoding for the CAVLC coefficient scanner. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package cavlc_pkg;

    localparam int DEPTH  = 16;
    localparam int TC_W   = 5;
    localparam int TZ_W   = 4;
    localparam int RUN_W  = 4;
    localparam int MAX_T1 = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_STATS = 2'd2,
        ST_EMIT  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cavlc_coeff_scan_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cavlc_coeff_scan_if                                                  |
// | Level/run stream from the scanner towards the VLC encoders.          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface cavlc_coeff_scan_if #(
    parameter int WIDTH = 9
);
    import cavlc_pkg::*;

    logic             coeff_valid;
    logic             coeff_ready;
    logic [WIDTH-1:0] coeff_level;
    logic [RUN_W-1:0] coeff_run;
    logic             coeff_last;

    modport master (
        output coeff_valid,
        output coeff_level,
        output coeff_run,
        output coeff_last,
        input  coeff_ready
    );

    modport slave (
        input  coeff_valid,
        input  coeff_level,
        input  coeff_run,
        input  coeff_last,
        output coeff_ready
    );

endinterface
`default_nettype wire

// File: rtl/cavlc_t1_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cavlc_t1_tracker                                                     |
// | Incremental TotalCoeff / TrailingOnes / sign counter; outputs are    |
// | the updated values including the current sample. Rev 1.0            |
// +----------------------------------------------------------------------+
module cavlc_t1_tracker
    import cavlc_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [TC_W-1:0]  tc_o,
    output logic [1:0]       t1_o,
    output logic [2:0]       signs_o
);

    logic [TC_W-1:0] tc_q,    tc_d;
    logic [1:0]      t1_q,    t1_d;
    logic [2:0]      signs_q, signs_d;
    logic            big_q,   big_d;
    logic            w_nz;
    logic            w_one;

    assign w_nz  = (data_i != '0);
    assign w_one = (data_i == WIDTH'(1)) || (data_i == {WIDTH{1'b1}});

    always_comb begin
        tc_d    = tc_q;
        t1_d    = t1_q;
        signs_d = signs_q;
        big_d   = big_q;
        if (clr_i) begin
            tc_d    = '0;
            t1_d    = '0;
            signs_d = '0;
            big_d   = 1'b0;
        end else if (en_i) begin
            if (w_nz) begin
                tc_d = tc_q + 1'b1;
            end
            // Trailing ones stop at the first magnitude above one
            if (w_one && !big_q && (t1_q != 2'(MAX_T1))) begin
                signs_d[t1_q] = data_i[WIDTH-1];
                t1_d          = t1_q + 2'd1;
            end
            if (w_nz && !w_one) begin
                big_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tc_q    <= '0;
            t1_q    <= '0;
            signs_q <= '0;
            big_q   <= 1'b0;
        end else begin
            tc_q    <= tc_d;
            t1_q    <= t1_d;
            signs_q <= signs_d;
            big_q   <= big_d;
        end
    end

    assign tc_o    = tc_d;
    assign t1_o    = t1_d;
    assign signs_o = signs_d;

endmodule
`default_nettype wire

// File: rtl/cavlc_coeff_scan.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cavlc_coeff_scan                                                     |
// | Reads a zigzag block in reverse, builds CAVLC stats, streams levels  |
// | with run_before. CAVLC_AC_MODE_EN adds ac_mode_i (skip index 0).     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module cavlc_coeff_scan #(
    parameter int WIDTH     = 9,
    parameter int addrWIDTH = 4,
    parameter int DEPTH     = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
`ifdef CAVLC_AC_MODE_EN
    input  logic                 ac_mode_i,
`endif
    output logic                 busy_o,
    output logic                 rd_en_o,
    output logic [addrWIDTH-1:0] rd_addr_o,
    input  logic [WIDTH-1:0]     rd_data_i,
    output logic                 stats_valid_o,
    output logic [4:0]           total_coeff_o,
    output logic [1:0]           trailing_ones_o,
    output logic [2:0]           t1_signs_o,
    output logic [3:0]           total_zeros_o,
    cavlc_coeff_scan_if.master   coeff_if,
    output logic                 done_o
);
    import cavlc_pkg::*;

    state_t                 state_q,     state_d;
    logic                   busy_q,      busy_d;
    logic                   rd_en_q,     rd_en_d;
    logic [addrWIDTH-1:0]   rd_addr_q,   rd_addr_d;
    logic                   cap_en_q,    cap_en_d;
    logic [addrWIDTH-1:0]   cap_addr_q,  cap_addr_d;
    logic                   ac_q,        ac_d;
    logic [WIDTH-1:0]       arr_q [DEPTH];
    logic [WIDTH-1:0]       arr_d [DEPTH];
    logic                   hi_found_q,  hi_found_d;
    logic [addrWIDTH-1:0]   hi_idx_q,    hi_idx_d;
    logic                   stats_vld_q, stats_vld_d;
    logic [TC_W-1:0]        tc_q,        tc_d;
    logic [1:0]             t1_q,        t1_d;
    logic [2:0]             sg_q,        sg_d;
    logic [TZ_W-1:0]        tz_q,        tz_d;
    logic                   done_q,      done_d;
    logic [addrWIDTH-1:0]   ptr_q,       ptr_d;
    logic                   passed_q,    passed_d;
    logic                   pend_q,      pend_d;
    logic [WIDTH-1:0]       pend_lvl_q,  pend_lvl_d;
    logic [RUN_W-1:0]       run_q,       run_d;
    logic                   cv_q,        cv_d;
    logic [WIDTH-1:0]       clvl_q,      clvl_d;
    logic [RUN_W-1:0]       crun_q,      crun_d;
    logic                   clast_q,     clast_d;

    logic                   w_ac_sel;
    logic                   w_start;
    logic [TC_W-1:0]        w_trk_tc;
    logic [1:0]             w_trk_t1;
    logic [2:0]             w_trk_sg;
    logic [addrWIDTH-1:0]   w_stop_addr;
    logic [WIDTH-1:0]       w_cur;
    logic                   w_stall;

`ifdef CAVLC_AC_MODE_EN
    assign w_ac_sel = ac_mode_i;
`else
    assign w_ac_sel = 1'b0;
`endif

    assign w_start     = start_i && (state_q == ST_IDLE);
    assign w_stop_addr = ac_q ? addrWIDTH'(1) : '0;
    assign w_cur       = arr_q[ptr_q];
    assign w_stall     = cv_q && !coeff_if.coeff_ready;

    cavlc_t1_tracker #(
        .WIDTH (WIDTH)
    ) u_t1_tracker (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (w_start),
        .en_i    (cap_en_q),
        .data_i  (rd_data_i),
        .tc_o    (w_trk_tc),
        .t1_o    (w_trk_t1),
        .signs_o (w_trk_sg)
    );

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        rd_en_d     = rd_en_q;
        rd_addr_d   = rd_addr_q;
        cap_en_d    = rd_en_q;
        cap_addr_d  = rd_addr_q;
        ac_d        = ac_q;
        arr_d       = arr_q;
        hi_found_d  = hi_found_q;
        hi_idx_d    = hi_idx_q;
        stats_vld_d = 1'b0;
        tc_d        = tc_q;
        t1_d        = t1_q;
        sg_d        = sg_q;
        tz_d        = tz_q;
        done_d      = 1'b0;
        ptr_d       = ptr_q;
        passed_d    = passed_q;
        pend_d      = pend_q;
        pend_lvl_d  = pend_lvl_q;
        run_d       = run_q;
        cv_d        = cv_q;
        clvl_d      = clvl_q;
        crun_d      = crun_q;
        clast_d     = clast_q;

        // Buffer data lags the address by one cycle
        if (cap_en_q) begin
            arr_d[cap_addr_q] = rd_data_i;
            if (!hi_found_q && (rd_data_i != '0)) begin
                hi_found_d = 1'b1;
                hi_idx_d   = cap_addr_q;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d    = ST_SCAN;
                    busy_d     = 1'b1;
                    rd_en_d    = 1'b1;
                    rd_addr_d  = addrWIDTH'(DEPTH - 1);
                    ac_d       = w_ac_sel;
                    arr_d[0]   = '0;
                    hi_found_d = 1'b0;
                    hi_idx_d   = '0;
                    tc_d       = '0;
                    t1_d       = '0;
                    sg_d       = '0;
                    tz_d       = '0;
                end
            end
            ST_SCAN: begin
                if (rd_en_q) begin
                    if (rd_addr_q == w_stop_addr) begin
                        rd_en_d   = 1'b0;
                        rd_addr_d = '0;
                    end else begin
                        rd_addr_d = rd_addr_q - 1'b1;
                    end
                end
                if (cap_en_q && (cap_addr_q == w_stop_addr)) begin
                    state_d     = ST_STATS;
                    stats_vld_d = 1'b1;
                    tc_d        = w_trk_tc;
                    t1_d        = w_trk_t1;
                    sg_d        = w_trk_sg;
                    tz_d        = (w_trk_tc == '0) ? '0 :
                                  TZ_W'(TC_W'(hi_idx_d) + TC_W'(1) - w_trk_tc);
                end
            end
            ST_STATS: begin
                if (tc_q == '0) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d  = ST_EMIT;
                    ptr_d    = hi_idx_q;
                    passed_d = 1'b0;
                    pend_d   = 1'b0;
                    run_d    = '0;
                end
            end
            ST_EMIT: begin
                if (!w_stall) begin
                    cv_d = 1'b0;
                    if (cv_q && clast_q) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        clast_d = 1'b0;
                        clvl_d  = '0;
                        crun_d  = '0;
                    end else if (passed_q) begin
                        if (pend_q) begin
                            cv_d    = 1'b1;
                            clvl_d  = pend_lvl_q;
                            crun_d  = run_q;
                            clast_d = 1'b1;
                            pend_d  = 1'b0;
                        end
                    end else begin
                        // A new nonzero closes the run of the pending one
                        if (w_cur != '0) begin
                            if (pend_q) begin
                                cv_d    = 1'b1;
                                clvl_d  = pend_lvl_q;
                                crun_d  = run_q;
                                clast_d = 1'b0;
                            end
                            pend_d     = 1'b1;
                            pend_lvl_d = w_cur;
                            run_d      = '0;
                        end else begin
                            run_d = run_q + 1'b1;
                        end
                        if (ptr_q == '0) begin
                            passed_d = 1'b1;
                        end else begin
                            ptr_d = ptr_q - 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            cap_en_q    <= 1'b0;
            cap_addr_q  <= '0;
            ac_q        <= 1'b0;
            arr_q       <= '{default: '0};
            hi_found_q  <= 1'b0;
            hi_idx_q    <= '0;
            stats_vld_q <= 1'b0;
            tc_q        <= '0;
            t1_q        <= '0;
            sg_q        <= '0;
            tz_q        <= '0;
            done_q      <= 1'b0;
            ptr_q       <= '0;
            passed_q    <= 1'b0;
            pend_q      <= 1'b0;
            pend_lvl_q  <= '0;
            run_q       <= '0;
            cv_q        <= 1'b0;
            clvl_q      <= '0;
            crun_q      <= '0;
            clast_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            cap_en_q    <= cap_en_d;
            cap_addr_q  <= cap_addr_d;
            ac_q        <= ac_d;
            arr_q       <= arr_d;
            hi_found_q  <= hi_found_d;
            hi_idx_q    <= hi_idx_d;
            stats_vld_q <= stats_vld_d;
            tc_q        <= tc_d;
            t1_q        <= t1_d;
            sg_q        <= sg_d;
            tz_q        <= tz_d;
            done_q      <= done_d;
            ptr_q       <= ptr_d;
            passed_q    <= passed_d;
            pend_q      <= pend_d;
            pend_lvl_q  <= pend_lvl_d;
            run_q       <= run_d;
            cv_q        <= cv_d;
            clvl_q      <= clvl_d;
            crun_q      <= crun_d;
            clast_q     <= clast_d;
        end
    end

    assign busy_o               = busy_q;
    assign rd_en_o              = rd_en_q;
    assign rd_addr_o            = rd_addr_q;
    assign stats_valid_o        = stats_vld_q;
    assign total_coeff_o        = tc_q;
    assign trailing_ones_o      = t1_q;
    assign t1_signs_o           = sg_q;
    assign total_zeros_o        = tz_q;
    assign done_o               = done_q;
    assign coeff_if.coeff_valid = cv_q;
    assign coeff_if.coeff_level = clvl_q;
    assign coeff_if.coeff_run   = crun_q;
    assign coeff_if.coeff_last  = clast_q;

endmodule
`default_nettype wire

// File: tb/tb_cavlc_coeff_scan.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cavlc_coeff_scan                                                  |
// | Directed bench with a registered zigzag-buffer model. Rev 1.0        |
// +----------------------------------------------------------------------+
module tb_cavlc_coeff_scan;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       busy, rd_en, stats_valid, done;
    logic [3:0] rd_addr;
    logic [8:0] rd_data = '0;
    logic [4:0] tc;
    logic [1:0] t1;
    logic [2:0] sg;
    logic [3:0] tz;
`ifdef CAVLC_AC_MODE_EN
    logic       ac_mode = 1'b0;
`endif

    always #5 clk = ~clk;

    cavlc_coeff_scan_if #(.WIDTH(9)) cif ();

    cavlc_coeff_scan dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .start_i         (start),
`ifdef CAVLC_AC_MODE_EN
        .ac_mode_i       (ac_mode),
`endif
        .busy_o          (busy),
        .rd_en_o         (rd_en),
        .rd_addr_o       (rd_addr),
        .rd_data_i       (rd_data),
        .stats_valid_o   (stats_valid),
        .total_coeff_o   (tc),
        .trailing_ones_o (t1),
        .t1_signs_o      (sg),
        .total_zeros_o   (tz),
        .coeff_if        (cif),
        .done_o          (done)
    );

    logic [8:0] mem [16];
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    int n_run  = 0;
    int n_fail = 0;

    // block observations
    int          stats_k, stats_cnt, done_k, done_cnt, last_k, stall_bad, extra_bad;
    bit          rd_bad, busy1, busy_at_done;
    logic [4:0]  s_tc;
    logic [1:0]  s_t1;
    logic [2:0]  s_sg;
    logic [3:0]  s_tz;
    logic [13:0] got [$];
    logic [13:0] exp_a [$];
    logic [13:0] exp_z [$];
    logic [13:0] exp_2 [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_block(input int rmode, input bit inj, input bit ac);
        int          nrd;
        bit          stalled;
        bit          injected;
        logic [13:0] prev;
        logic [13:0] cur;
        nrd = ac ? 15 : 16;
        stalled = 0; injected = 0; prev = '0;
        got.delete();
        stats_k = -1; stats_cnt = 0; done_k = -1; done_cnt = 0; last_k = -1;
        stall_bad = 0; extra_bad = 0; rd_bad = 0; busy1 = 0; busy_at_done = 1;
        @(negedge clk);
        start = 1'b1;
`ifdef CAVLC_AC_MODE_EN
        ac_mode = ac;
`endif
        @(posedge clk);
        for (int k = 1; k <= 400 && done_k < 0; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (inj && !injected && cif.coeff_valid) begin
                start = 1'b1;
                injected = 1;
            end
            if (k <= nrd) begin
                if (!(rd_en === 1'b1 && rd_addr === 4'(16 - k))) rd_bad = 1;
            end else if (rd_en !== 1'b0) rd_bad = 1;
            if (k == 1) busy1 = busy;
            if (stats_valid) begin
                stats_cnt++;
                if (stats_k < 0) begin
                    stats_k = k; s_tc = tc; s_t1 = t1; s_sg = sg; s_tz = tz;
                end
            end
            cur = {cif.coeff_level, cif.coeff_run, cif.coeff_last};
            if (stalled && !(cif.coeff_valid === 1'b1 && cur === prev)) stall_bad++;
            if (done) begin
                done_k = k; done_cnt++; busy_at_done = busy;
            end
            cif.coeff_ready = (rmode == 0) ? 1'b1 : ((k % 3) == 0);
            if (cif.coeff_valid) begin
                if (cif.coeff_ready) begin
                    got.push_back(cur);
                    if (cif.coeff_last) last_k = k;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    prev = cur;
                end
            end else begin
                stalled = 0;
            end
        end
        start = 1'b0;
        cif.coeff_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (rd_en || stats_valid || cif.coeff_valid || done || busy) extra_bad++;
        end
    endtask

    task automatic check_block(input string tag, input int exp_sk, input logic [4:0] e_tc,
                               input logic [1:0] e_t1, input logic [2:0] e_sg,
                               input logic [3:0] e_tz, input logic [13:0] exp_q[$]);
        chk({tag, ".rd_seq"}, 32'(rd_bad), 0);
        chk({tag, ".busy_start"}, 32'(busy1), 1);
        chk({tag, ".stats_cycle"}, stats_k, exp_sk);
        chk({tag, ".stats_pulses"}, stats_cnt, 1);
        chk({tag, ".tc"}, 32'(s_tc), 32'(e_tc));
        chk({tag, ".t1"}, 32'(s_t1), 32'(e_t1));
        chk({tag, ".t1_signs"}, 32'(s_sg), 32'(e_sg));
        chk({tag, ".tz"}, 32'(s_tz), 32'(e_tz));
        chk({tag, ".stream_len"}, got.size(), exp_q.size());
        foreach (exp_q[i])
            chk($sformatf("%s.entry%0d", tag, i), (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF,
                32'(exp_q[i]));
        chk({tag, ".done_cycle"}, done_k, (exp_q.size() == 0) ? exp_sk + 1 : last_k + 1);
        chk({tag, ".done_pulses"}, done_cnt, 1);
        chk({tag, ".busy_at_done"}, 32'(busy_at_done), 0);
        chk({tag, ".stall_hold"}, stall_bad, 0);
        chk({tag, ".quiet_after"}, extra_bad, 0);
    endtask

    task automatic load_a();
        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem[1] = 9'd3;
        mem[2] = 9'h1FF;
        mem[5] = 9'h1FF;
        mem[6] = 9'd1;
        mem[8] = 9'd1;
    endtask

    initial begin
        // {level, run, last} in emission order
        exp_a = '{{9'h001, 4'd1, 1'b0}, {9'h001, 4'd0, 1'b0}, {9'h1FF, 4'd2, 1'b0},
                  {9'h1FF, 4'd0, 1'b0}, {9'h003, 4'd1, 1'b1}};
        exp_z.delete();
        for (int i = 0; i < 16; i++) exp_2.push_back({9'h002, 4'd0, (i == 15)});

        cif.coeff_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.busy", 32'(busy), 0);
        chk("reset.rd_en", 32'(rd_en), 0);
        chk("reset.rd_addr", 32'(rd_addr), 0);
        chk("reset.stats_valid", 32'(stats_valid), 0);
        chk("reset.stats", {tc, t1, sg, tz}, 0);
        chk("reset.coeff", {cif.coeff_valid, cif.coeff_level, cif.coeff_run, cif.coeff_last}, 0);
        chk("reset.done", 32'(done), 0);
        @(negedge clk);
        rst = 1'b0;

        load_a();
        run_block(0, 0, 0);
        check_block("A", 18, 5'd5, 2'd3, 3'b100, 4'd4, exp_a);

        for (int i = 0; i < 16; i++) mem[i] = '0;
        run_block(0, 0, 0);
        check_block("ZERO", 18, 5'd0, 2'd0, 3'b000, 4'd0, exp_z);

        for (int i = 0; i < 16; i++) mem[i] = 9'd2;
        run_block(0, 0, 0);
        check_block("ALL2", 18, 5'd16, 2'd0, 3'b000, 4'd0, exp_2);

        load_a();
        run_block(1, 0, 0);
        check_block("BP", 18, 5'd5, 2'd3, 3'b100, 4'd4, exp_a);

        run_block(1, 1, 0);
        check_block("BP_START", 18, 5'd5, 2'd3, 3'b100, 4'd4, exp_a);

        // reset during SCAN, with start asserted alongside it
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("RST.in_scan", 32'(rd_en), 1);
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("RST.busy", 32'(busy), 0);
        chk("RST.rd_en", 32'(rd_en), 0);
        chk("RST.rd_addr", 32'(rd_addr), 0);
        chk("RST.valid", 32'(cif.coeff_valid), 0);
        chk("RST.stats", {stats_valid, tc, t1, sg, tz}, 0);
        chk("RST.done", 32'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        run_block(0, 0, 0);
        check_block("AFTER_RST", 18, 5'd5, 2'd3, 3'b100, 4'd4, exp_a);

`ifdef CAVLC_AC_MODE_EN
        run_block(0, 0, 1);
        check_block("AC", 17, 5'd5, 2'd3, 3'b100, 4'd4, exp_a);
        ac_mode = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cavlc_coeff_scan.md
Name: cavlc_coeff_scan

Overview:
- Downstream neighbour of the zigzag buffer stage; drives its read port (read_en_i / read_addr_i) and consumes dob_o.
- Per 4x4 block, reads the 16 zigzag-ordered residuals in reverse order (addr 15→0) into a local register array and computes CAVLC statistics: TotalCoeff, TrailingOnes, trailing-one signs, TotalZeros.
- Then streams each nonzero level with its run_before over a valid/ready handshake to the level/run VLC encoders.

Parameters:
- WIDTH, 9, residual coefficient width (two's complement).
- addrWIDTH, 4, zigzag buffer address width.
- DEPTH, 16, coefficients per block.

Ports:
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  one-cycle pulse; starts a block. Ignored while busy_o=1.
- busy_o  out  1  high from the cycle after an accepted start until done_o.
- rd_en_o  out  1  read enable to the zigzag buffer.
- rd_addr_o  out  addrWIDTH  read address to the zigzag buffer.
- rd_data_i  in  WIDTH  buffer read data; registered, valid 1 cycle after rd_en_o.
- stats_valid_o  out  1  one-cycle pulse when the statistics outputs are valid.
- total_coeff_o  out  5  TotalCoeff, range 0..16.
- trailing_ones_o  out  2  TrailingOnes, range 0..3.
- t1_signs_o  out  3  bit i = sign of the i-th trailing one counted from the highest frequency; 1 = negative.
- total_zeros_o  out  4  zeros below the highest nonzero index.
- coeff_valid_o  out  1  stream valid.
- coeff_ready_i  in  1  stream ready.
- coeff_level_o  out  WIDTH  nonzero level, emitted in reverse zigzag order.
- coeff_run_o  out  4  run_before: zeros between this coefficient and the next lower-index nonzero (or index 0).
- coeff_last_o  out  1  marks the lowest-index nonzero.
- done_o  out  1  one-cycle pulse at the end of the block.

Behaviour:
- Reset: state IDLE; every output is 0. Stats registers clear to 0.
- FSM: IDLE → SCAN → STATS → EMIT → IDLE.
  - STATS → IDLE directly when total_coeff = 0.
- IDLE:
  - start_i accepted at edge T.
  - From T+1: rd_en_o=1 for exactly 16 cycles, with rd_addr_o = 15, 14, …, 0.
- SCAN:
  - Data for each address is captured the following cycle (T+2..T+17) into array[addr].
  - Stats are updated incrementally as each value arrives, in reverse order:
    - nonzero → total_coeff++.
    - Record the highest nonzero index.
    - Trailing ones counted while |v|==1 and no |v|>1 has been seen yet, saturating at 3; the sign of each is recorded into t1_signs.
- STATS:
  - At T+18, total_zeros = (hi_idx+1) − total_coeff, or 0 if total_coeff=0.
  - stats_valid_o pulses at T+18.
  - Stats outputs hold their values until the next accepted start.
  - If total_coeff=0: done_o pulses at T+19 and no stream is emitted.
- EMIT:
  - A pointer walks from hi_idx down, one index per cycle, holding at most one pending nonzero.
  - Zeros increment the run counter.
  - On the next nonzero, or when the pointer passes index 0, the pending entry is presented with its run.
  - coeff_last_o=1 when the pointer passes 0.
- Handshake:
  - coeff_valid_o stays high, with level/run/last stable, until coeff_ready_i=1 on a rising edge.
  - The walk stalls while an output is pending and not accepted.
  - valid never depends combinationally on ready.
- done_o pulses in the cycle after the handshake that carries coeff_last_o=1; busy_o falls in that same cycle.
- Reset mid-operation: return to IDLE immediately and drop rd_en_o, coeff_valid_o and busy_o the cycle after rst_i is sampled.
- start_i together with rst_i: reset wins.
- Sum of coeff_run_o over a block always equals total_zeros_o.

Optional Feature:
- Macro: CAVLC_AC_MODE_EN.
- Defined: adds input ac_mode_i (1 bit), sampled at start.
  - When 1, index 0 is not read: SCAN takes 15 cycles (addr 15..1) and array[0] is treated as zero.
  - Every later timing point, including stats_valid_o and done_o, moves 1 cycle earlier.
  - The maximum total_coeff is 15.
- Undefined: the port is absent and all 16 indices are always scanned.

Decomposition:
- Package cavlc_pkg holds:
  - FSM state encoding.
  - DEPTH, plus widths for total_coeff, total_zeros and run.
  - Constant MAX_T1 = 3.
- One sub-module, cavlc_t1_tracker: the incremental TrailingOnes/sign/TotalCoeff counter used during SCAN.

Test Plan:
- Zigzag input 0,3,−1,0,0,−1,1,0,1,0×7, ready always high:
  - stats at T+18: TC=5, T1=3, t1_signs=3'b100, TZ=4.
  - Stream: (1,1), (1,0), (−1,2), (−1,0), (3,1, last).
  - done_o one cycle after the last handshake.
- All-zero block → stats_valid_o at T+18 with TC=0, TZ=0; done_o at T+19; coeff_valid_o never asserts.
- All 16 = 2 → TC=16, T1=0, TZ=0; 16 entries, all with run 0; last at index 0.
- Backpressure: previous block with coeff_ready_i toggling 1-of-3 cycles → identical stream, with level/run held stable while stalled.
- start_i pulsed during EMIT is ignored; rst_i asserted mid-SCAN → all outputs 0 next cycle; a following start runs a clean block.
- With CAVLC_AC_MODE_EN and ac_mode_i=1 on the first vector → index 0 is not read; stats_valid_o at T+17 with the same statistics.
